// File: rtl/tcb_lite_lib_byteena2logsize.sv
// TCB-Lite byte-enable subordinate to log-size manager bridge.
// A byte-enable request is split into naturally aligned power-of-two chunks,
// issued one at a time in ascending offset order. Read data and errors of
// all chunks are merged into a single response strobe.
// Optional build macro TCB_LITE_BYTEENA2LOGSIZE_ABORT_EN: a chunk that returns
// man_err stops the remaining chunks and responds immediately.
module tcb_lite_lib_byteena2logsize #(
    parameter  int ADR = 32,
    parameter  int DAT = 32,
    parameter  int DLY = 1,
    localparam int BEN = DAT/8,
    localparam int OFF = $clog2(BEN),
    localparam int SZW = $clog2(OFF+1)
)(
    input  logic           clk,
    input  logic           rst,
    // byte-enable subordinate port
    input  logic           sub_vld,
    output logic           sub_rdy,
    input  logic           sub_wen,
    input  logic [ADR-1:0] sub_adr,
    input  logic [BEN-1:0] sub_ben,
    input  logic [DAT-1:0] sub_wdt,
    output logic           sub_rsp_vld,
    output logic [DAT-1:0] sub_rdt,
    output logic           sub_err,
    // log-size manager port
    output logic           man_vld,
    input  logic           man_rdy,
    output logic           man_wen,
    output logic [ADR-1:0] man_adr,
    output logic [SZW-1:0] man_siz,
    output logic [DAT-1:0] man_wdt,
    input  logic [DAT-1:0] man_rdt,
    input  logic           man_err
);

    localparam int CNW = (DLY > 1) ? $clog2(DLY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic               wen_r;
    logic [ADR-1:OFF]   adr_r;
    logic [DAT-1:0]     wdt_r;
    logic [BEN-1:0]     rem;      // byte lanes still to be transferred
    logic [DAT-1:0]     acc;      // merged read data
    logic               err;
    logic [CNW-1:0]     cnt;

    int                 lo;       // offset of the current chunk
    int                 siz_i;    // log2 size of the current chunk
    logic [BEN-1:0]     msk;
    logic [BEN-1:0]     chk_ben;  // lanes covered by the current chunk
    logic [BEN-1:0]     rem_nxt;
    logic [DAT-1:0]     wdt_sh;
    logic [DAT-1:0]     rdt_sh;
    logic [DAT-1:0]     chk_wdt;
    logic [DAT-1:0]     acc_nxt;

    // sub-word address bits carry no meaning on a byte-enable port
    logic               unused_adr;
    assign unused_adr = ^sub_adr[OFF-1:0];

    // pick the largest aligned, fully enabled chunk starting at the lowest remaining lane
    always_comb begin
        lo      = 0;
        siz_i   = 0;
        msk     = '0;
        chk_ben = '0;
        for (int i = BEN-1; i >= 0; i--) begin
            if (rem[i]) lo = i;
        end
        for (int s = 0; s <= OFF; s++) begin
            for (int j = 0; j < BEN; j++) begin
                msk[j] = (j >= lo) && (j < lo + (1 << s));
            end
            if ((lo % (1 << s) == 0) && (lo + (1 << s) <= BEN) && ((rem & msk) == msk)) begin
                siz_i   = s;
                chk_ben = msk;
            end
        end
    end

    // route write data down to bit 0 and read data up into the chunk's lanes
    always_comb begin
        wdt_sh  = wdt_r >> (8*lo);
        rdt_sh  = man_rdt << (8*lo);
        chk_wdt = '0;
        acc_nxt = acc;
        for (int j = 0; j < BEN; j++) begin
            if (j < (1 << siz_i)) chk_wdt[8*j +: 8] = wdt_sh[8*j +: 8];
            if (chk_ben[j])       acc_nxt[8*j +: 8] = rdt_sh[8*j +: 8];
        end
        rem_nxt = rem & ~chk_ben;
    end

    // request/chunk/response sequencer; one sub transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wen_r <= 1'b0;
            adr_r <= '0;
            wdt_r <= '0;
            rem   <= '0;
            acc   <= '0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sub_vld) begin
                        wen_r <= sub_wen;
                        adr_r <= sub_adr[ADR-1:OFF];
                        wdt_r <= sub_wdt;
                        rem   <= sub_ben;
                        acc   <= '0;
                        err   <= 1'b0;
                        state <= (sub_ben == '0) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    if (man_rdy) begin
                        cnt   <= CNW'(DLY-1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (!wen_r) acc <= acc_nxt;
                        err   <= err | man_err;
                        rem   <= rem_nxt;
                        state <= (rem_nxt == '0) ? RESP : ISSUE;
`ifdef TCB_LITE_BYTEENA2LOGSIZE_ABORT_EN
                        if (man_err) begin
                            rem   <= '0;
                            state <= RESP;
                        end
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sub_rdy     = (state == IDLE);
    assign sub_rsp_vld = (state == RESP);
    assign sub_rdt     = acc;
    assign sub_err     = err;

    assign man_vld     = (state == ISSUE);
    assign man_wen     = wen_r;
    assign man_adr     = {adr_r, lo[OFF-1:0]};
    assign man_siz     = siz_i[SZW-1:0];
    assign man_wdt     = chk_wdt;

endmodule
